mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

- Round-robin arbiter and sequencer for the shared 8-to-1 32-bit operand/result multiplexer.
- Up to eight requesters compete for a single registered 32-bit output channel.
- Each cycle it picks one requester fairly, drives the mux select, captures the selected word into an output register, and hands it downstream with a valid/ready handshake.
- Sits between the producing units (ALU, load unit, immediate generator, etc.) and the single consumer (register-file write port or bus).

## Interface
Parameters:
- DATA_W, 32, width of each data lane and of out_data.
- NUM_REQ, 8, number of requesters; fixed at 8, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  8  per-requester request; req[i] means in_data lane i is valid.
- in_data  input  8*DATA_W  flattened lanes; lane i = bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- gnt  output  8  one-hot grant pulse; high for exactly the cycle in which lane i is captured.
- out_valid  output  1  out_data/out_src hold a word not yet accepted.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  captured word.
- out_src  output  3  index of the requester that supplied out_data.
- lock  input  8  per-requester burst lock; present only with ARB_LOCK_EN.

## Operation
- **Capture enable:**
  - `load = |req && (!out_valid || out_ready)`.
  - If `load` is 0, gnt = 0 and no state changes except the out_valid clear below.
- **Pick:**
  - Winner is the first i with req[i]=1, searching ptr, ptr+1, …, ptr+7 modulo 8.
  - The search wraps from 7 to 0.
- **On load:**
  - out_data <= lane[winner], out_src <= winner, out_valid <= 1, gnt[winner] = 1 (combinational, same cycle).
  - ptr <= (winner+1) mod 8; the increment is 3-bit wrap-around, so winner 7 gives ptr 0.
- **Output clear:** out_valid && out_ready && !load → out_valid <= 0; out_data and out_src keep their last value.
- **Simultaneous accept and load:** out_valid stays 1 with the new word; no bubble.
- **Requester duties:**
  - A requester must hold req and its lane stable until it sees gnt.
  - Dropping req before gnt is legal: the request is simply withdrawn.
- **Stall:** out_valid && !out_ready → no grant; out_data, out_src and ptr are frozen.
- **Fairness:** every continuously asserted requester is granted within 8 loads.

## Timing
- Latency: req to out_valid is 1 cycle. gnt is combinational in the capture cycle.
- Throughput: one word per cycle while out_ready=1.
- Reset value of every output and state (async on rst_n=0, held until release):

| Signal | Reset value |
|---|---|
| out_valid | 0 |
| out_data | 0 |
| out_src | 0 |
| ptr | 0 |
| gnt | 0 (combinationally forced while rst_n=0) |

- Reset mid-transfer: the word in the output register is discarded and no grant is issued. The first post-reset search starts at requester 0.
- No combinational path from out_ready to out_data. out_ready → gnt is combinational, which is permitted.

## Configuration
- Macro: ARB_LOCK_EN.
- **Defined:**
  - The lock port exists.
  - If lock[out_src] && req[out_src] at a load, the winner is forced to out_src, overriding round-robin, and ptr is not advanced.
  - Lock is ignored while out_valid=0 after reset.
- **Undefined:**
  - The lock port is absent.
  - Pure round-robin as above.

## Structure
- Shared package arb_pkg:
  - NUM_REQ=8, SEL_W=3, DATA_W=32.
  - typedef req_vec_t (8 bits), typedef sel_t (3 bits).
- One sub-module, rr_pick8: purely combinational.
  - Inputs: req, ptr. Outputs: winner index, any-valid flag, one-hot vector.
  - Instantiated once; the top holds the ptr/output registers and the 8:1 data select.

## Test plan
- Reset release with req=8'h00 → out_valid=0, gnt=0, out_data=0, out_src=0 for 5 cycles.
- req=8'hFF held, out_ready=1, lane i = 32'hA000_0000+i → out_src sequence 0,1,…,7,0 on consecutive cycles; gnt one-hot each cycle.
- ptr=6 after grant to 5, req=8'h41 → grant 6 then 0 (wrap); out_data matches lanes 6 and 0.
- out_ready=0 for 4 cycles with req=8'h03 pending → out_valid=1, out_data frozen, gnt=0; first cycle out_ready=1 → new word captured same cycle, no bubble.
- rst_n pulsed low mid-stream with out_valid=1 → out_valid=0 immediately (asynchronous); after release with req=8'h80 → grant 7, out_src=7.
- With ARB_LOCK_EN, req=8'h0C, lock=8'h04 → requester 2 granted on 3 consecutive loads; lock dropped → next grant is 3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the 8-way round-robin output arbiter.
// Requester vectors and select indices used by the picker and the top.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 32;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0]   sel_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin search over eight requests.
// Finds the first set request at ptr, ptr+1, ... wrapping past 7.
module rr_pick8
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output sel_t     winner,
  output logic     any,
  output req_vec_t onehot
);

  // Scan farthest-first so the nearest request after ptr wins.
  always_comb begin
    sel_t idx;
    idx    = '0;
    winner = '0;
    any    = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) winner = idx;
    end
    onehot = any ? (req_vec_t'(1) << winner) : '0;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin 8:1 arbiter feeding one registered valid/ready output.
// Optional burst lock enabled by defining ARB_LOCK_EN.
module mux8_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
`ifdef ARB_LOCK_EN
  output logic [2:0]                out_src,
  input  logic [NUM_REQ-1:0]        lock
`else
  output logic [2:0]                out_src
`endif
);
  import arb_pkg::*;

  sel_t        ptr;
  sel_t        pick;
  sel_t        sel;
  req_vec_t    pick_oh;
  logic        any;
  logic        load;
  logic        lock_hit;
  logic [DATA_W-1:0] word;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .any    (any),
    .onehot (pick_oh)
  );

`ifdef ARB_LOCK_EN
  logic primed;

  // Lock is honoured only once out_src names a real captured word.
  always_comb begin
    lock_hit = primed && lock[out_src] && req[out_src];
  end

  // Track whether any word has been captured since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    primed <= 1'b0;
    else if (load) primed <= 1'b1;
  end
`else
  // Pure round-robin: no locked requester can override the search.
  always_comb begin
    lock_hit = 1'b0;
  end
`endif

  // Capture when something is requested and the output slot frees up.
  always_comb begin
    load = any && (!out_valid || out_ready);
    sel  = lock_hit ? out_src : pick;
    word = in_data[DATA_W*int'(sel) +: DATA_W];
  end

  // Grant pulse, suppressed while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && load)
      gnt = lock_hit ? (req_vec_t'(1) << out_src) : pick_oh;
  end

  // Output register, source index and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_src   <= sel;
      if (!lock_hit) ptr <= sel + sel_t'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_mux8_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [255:0] in_data;
  logic [7:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_src;
`ifdef ARB_LOCK_EN
  logic [7:0]  lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ARB_LOCK_EN
    .out_src   (out_src),
    .lock      (lock)
`else
    .out_src   (out_src)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid cyc %0d got %b exp 0", c, out_valid);
      end
      checks++;
      if (gnt !== 8'h00) begin
        errors++;
        $display("FAIL reset_gnt cyc %0d got %h exp 00", c, gnt);
      end
      checks++;
      if (out_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_data cyc %0d got %h exp 0", c, out_data);
      end
      checks++;
      if (out_src !== 3'd0) begin
        errors++;
        $display("FAIL reset_src cyc %0d got %0d exp 0", c, out_src);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]  eg;
    logic [2:0]  es;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req = 8'hFF;
      out_ready = 1'b1;
      es = 3'(k % 8);
      eg = 8'h01 << es;
      #1;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL rr_gnt step %0d got %h exp %h", k, gnt, eg);
      end
      @(posedge clk); #1;
      checks++;
      if (out_src !== es || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_src step %0d got %0d/%b exp %0d/1",
                 k, out_src, out_valid, es);
      end
      checks++;
      if (out_data !== 32'hA000_0000 + 32'(es)) begin
        errors++;
        $display("FAIL rr_data step %0d got %h exp %h",
                 k, out_data, 32'hA000_0000 + 32'(es));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] eg [3] = '{8'h20, 8'h40, 8'h01};
    logic [7:0] rq [3] = '{8'h20, 8'h41, 8'h41};
    logic [2:0] es [3] = '{3'd5, 3'd6, 3'd0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = rq[k];
      #1;
      checks++;
      if (gnt !== eg[k]) begin
        errors++;
        $display("FAIL wrap_gnt step %0d got %h exp %h", k, gnt, eg[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_src !== es[k] ||
          out_data !== 32'hA000_0000 + 32'(es[k])) begin
        errors++;
        $display("FAIL wrap_out step %0d got %0d/%h exp %0d/%h",
                 k, out_src, out_data, es[k], 32'hA000_0000 + 32'(es[k]));
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = 8'h03;
      out_ready = 1'b0;
      #1;
      checks++;
      if (gnt !== 8'h00) begin
        errors++;
        $display("FAIL stall_gnt cyc %0d got %h exp 00", c, gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 ||
          out_src !== 3'd0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got %b/%h/%0d exp 1/a0000000/0",
                 c, out_valid, out_data, out_src);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h02) begin
      errors++;
      $display("FAIL stall_release_gnt got %h exp 02", gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd1 ||
        out_data !== 32'hA000_0001) begin
      errors++;
      $display("FAIL stall_release_out got %b/%0d/%h exp 1/1/a0000001",
               out_valid, out_src, out_data);
    end
    @(negedge clk);
    req = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hA000_0001 ||
        out_src !== 3'd1) begin
      errors++;
      $display("FAIL drain got %b/%h/%0d exp 0/a0000001/1",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_prefill got %b exp 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got %b/%h/%h exp 0/0/00",
               out_valid, out_data, gnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h80;
    #1;
    checks++;
    if (gnt !== 8'h80) begin
      errors++;
      $display("FAIL post_reset_gnt got %h exp 80", gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (out_src !== 3'd7 || out_data !== 32'hA000_0007 ||
        out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_out got %0d/%h/%b exp 7/a0000007/1",
               out_src, out_data, out_valid);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = 8'h0C;
      lock = (k < 3) ? 8'h04 : 8'h00;
      #1;
      checks++;
      if (gnt !== ((k < 3) ? 8'h04 : 8'h08)) begin
        errors++;
        $display("FAIL lock_gnt step %0d got %h exp %h",
                 k, gnt, (k < 3) ? 8'h04 : 8'h08);
      end
      @(posedge clk); #1;
    end
    lock = 8'h00;
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++)
      in_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
`ifdef ARB_LOCK_EN
    lock = 8'h00;
`endif
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
